imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the word-addressed instruction memory.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master: the loader side (consumes bytes, drives memory writes).
// slave:  the stream source / memory side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream program loader. Packs bytes into 32-bit words
// and writes them to consecutive word addresses of the instruction memory,
// holding the CPU while a load is in progress.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] n_words;
  logic [31:0] pack;
  logic [31:0] pack_nx;
  logic        accept;
  logic        fire;
  logic        last_byte;
  logic        can_start;

  // in_ready is a pure function of state so the handshake has no comb path
  // back through in_valid.
  assign accept    = (state == S_HDR) || (state == S_DATA);
  assign fire      = bus.in_valid & accept;
  assign last_byte = fire && (byte_cnt == 2'd3);
  assign can_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign pack_nx   = BIG_ENDIAN ? {pack[23:0], bus.in_data} : {bus.in_data, pack[31:8]};
  assign bus.in_ready = accept;
  assign busy         = accept;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and status outputs. The final word's write and the move to
  // DONE happen on the same edge, so done rises with the last mem_we.
  always_comb begin
    state_nx = state;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nx = S_HDR;
      S_HDR: begin
        cpu_hold = 1'b1;
        if (last_byte) begin
          if (pack_nx == 32'd0)                     state_nx = S_DONE;
          else if (pack_nx > 32'(DEPTH_WORDS))      state_nx = S_ERR;
          else                                      state_nx = S_DATA;
        end
      end
      S_DATA: begin
        cpu_hold = 1'b1;
        if (last_byte && (word_cnt == n_words - 32'd1)) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_HDR;
      end
      S_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_nx = S_HDR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte packing, header latch and one-cycle write strobe. Reset drops any
  // partially packed word without writing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt      <= 2'd0;
      word_cnt      <= 32'd0;
      n_words       <= 32'd0;
      pack          <= 32'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 32'd0;
    end else begin
      bus.mem_we <= 1'b0;
      if (can_start) begin
        byte_cnt <= 2'd0;
        word_cnt <= 32'd0;
        pack     <= 32'd0;
      end else if (fire) begin
        pack     <= pack_nx;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (state == S_HDR) begin
            n_words <= pack_nx;
          end else begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= pack_nx;
            bus.mem_addr  <= BASE_ADDR + {word_cnt[29:0], 2'b00};
            word_cnt      <= word_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a big-endian instance (base 0) driven from a vector
// table plus reset-mid-load, and a little-endian instance (base 0x100) for
// byte order and start-while-busy. Writes are checked against a queue of
// expected {addr,data} pushed as the stream is driven.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset;
  logic sel;          // 0: drive instance A, 1: drive instance B
  logic start_drv;
  logic vld;
  logic [7:0] din;

  logic hold_a, busy_a, done_a, err_a;
  logic hold_b, busy_b, done_b, err_b;

  imem_loader_if ifa();
  imem_loader_if ifb();

  assign ifa.in_valid = vld & ~sel;
  assign ifb.in_valid = vld & sel;
  assign ifa.in_data  = din;
  assign ifb.in_data  = din;

  imem_loader #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h0), .BIG_ENDIAN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_drv & ~sel), .bus(ifa),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a));

  imem_loader #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h100), .BIG_ENDIAN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_drv & sel), .bus(ifb),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_a = 0;
  int wr_b = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  logic [63:0] e_a, e_b;

  typedef struct {
    string       name;
    logic [31:0] n;
    logic [31:0] w[3];
    bit          gaps;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (ifa.mem_we === 1'b1) begin
      wr_a++;
      if (q_a.size() == 0) chk("A unexpected write addr", ifa.mem_addr, 32'hFFFF_FFFF);
      else begin
        e_a = q_a.pop_front();
        chk("A write addr", ifa.mem_addr, e_a[63:32]);
        chk("A write data", ifa.mem_wdata, e_a[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.mem_we === 1'b1) begin
      wr_b++;
      if (q_b.size() == 0) chk("B unexpected write addr", ifb.mem_addr, 32'hFFFF_FFFF);
      else begin
        e_b = q_b.pop_front();
        chk("B write addr", ifb.mem_addr, e_b[63:32]);
        chk("B write data", ifb.mem_wdata, e_b[31:0]);
      end
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    logic rdy;
    vld = 1'b1;
    din = b;
    @(negedge clk);
    rdy = sel ? ifb.in_ready : ifa.in_ready;
    while (!rdy && t < 50) begin
      t++;
      @(negedge clk);
      rdy = sel ? ifb.in_ready : ifa.in_ready;
    end
    if (!rdy) chk("byte accept timeout", 32'(rdy), 32'd1);
    step();
    vld = 1'b0;
    if (gap) step();
  endtask

  task automatic send_word(input logic [31:0] x, input bit le, input bit gap);
    for (int k = 0; k < 4; k++)
      send_byte(le ? x[8*k +: 8] : x[8*(3-k) +: 8], gap);
  endtask

  task automatic run_vec(input vec_t v);
    int w0;
    w0 = wr_a;
    pulse_start();
    chk({v.name, " busy after start"}, 32'(busy_a), 32'd1);
    chk({v.name, " hold after start"}, 32'(hold_a), 32'd1);
    send_word(v.n, 1'b0, v.gaps);
    if (v.exp_err) begin
      chk({v.name, " err"}, 32'(err_a), 32'd1);
      chk({v.name, " err hold"}, 32'(hold_a), 32'd1);
      chk({v.name, " err in_ready"}, 32'(ifa.in_ready), 32'd0);
      chk({v.name, " err busy"}, 32'(busy_a), 32'd0);
      repeat (3) step();
      chk({v.name, " err writes"}, 32'(wr_a - w0), 32'd0);
      pulse_start();
      chk({v.name, " recover busy"}, 32'(busy_a), 32'd1);
      chk({v.name, " recover err"}, 32'(err_a), 32'd0);
      send_word(32'd0, 1'b0, 1'b0);
      chk({v.name, " recover done"}, 32'(done_a), 32'd1);
    end else if (v.n == 0) begin
      chk({v.name, " done next cycle"}, 32'(done_a), 32'd1);
      chk({v.name, " hold released"}, 32'(hold_a), 32'd0);
      repeat (2) step();
      chk({v.name, " writes"}, 32'(wr_a - w0), 32'd0);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        chk({v.name, " busy in data"}, 32'(busy_a), 32'd1);
        q_a.push_back({32'(4 * i), v.w[i]});
        send_word(v.w[i], 1'b0, v.gaps);
      end
      chk({v.name, " done"}, 32'(done_a), 32'd1);
      step();
      chk({v.name, " hold released"}, 32'(hold_a), 32'd0);
      chk({v.name, " in_ready idle"}, 32'(ifa.in_ready), 32'd0);
      chk({v.name, " writes"}, 32'(wr_a - w0), v.n);
      chk({v.name, " queue drained"}, 32'(q_a.size()), 32'd0);
    end
  endtask

  initial begin
    int w0;
    vecs[0] = '{"basic",  32'd2,    '{32'h24080005, 32'h0000000C, 32'h0}, 1'b0, 1'b0};
    vecs[1] = '{"gaps",   32'd2,    '{32'h24080005, 32'h0000000C, 32'h0}, 1'b1, 1'b0};
    vecs[2] = '{"zero",   32'd0,    '{32'h0, 32'h0, 32'h0},               1'b0, 1'b0};
    vecs[3] = '{"toobig", 32'd2049, '{32'h0, 32'h0, 32'h0},               1'b0, 1'b1};
    vecs[4] = '{"three",  32'd3,    '{32'hDEADBEEF, 32'h00FF00FF, 32'h8000_0001}, 1'b1, 1'b0};

    sel = 1'b0; start_drv = 1'b0; vld = 1'b0; din = 8'h00;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    chk("reset A hold", 32'(hold_a), 32'd0);
    chk("reset A ready", 32'(ifa.in_ready), 32'd0);
    chk("reset A flags", {29'd0, busy_a, done_a, err_a}, 32'd0);
    chk("reset A we", 32'(ifa.mem_we), 32'd0);
    chk("reset A addr", ifa.mem_addr, 32'h0);
    chk("reset B addr", ifb.mem_addr, 32'h100);
    chk("reset B wdata", ifb.mem_wdata, 32'h0);

    // Bytes offered in IDLE are not taken.
    vld = 1'b1; din = 8'hAA;
    step();
    chk("idle ignores byte", 32'(ifa.in_ready), 32'd0);
    vld = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after 6 of 12 data bytes: only word 0 lands.
    w0 = wr_a;
    pulse_start();
    send_word(32'd3, 1'b0, 1'b0);
    q_a.push_back({32'h0, 32'h11223344});
    send_word(32'h11223344, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset hold", 32'(hold_a), 32'd0);
    chk("midreset ready", 32'(ifa.in_ready), 32'd0);
    chk("midreset flags", {29'd0, busy_a, done_a, err_a}, 32'd0);
    chk("midreset addr", ifa.mem_addr, 32'h0);
    chk("midreset wdata", ifa.mem_wdata, 32'h0);
    repeat (3) step();
    chk("midreset writes", 32'(wr_a - w0), 32'd1);

    // Little-endian instance, with a start pulse in the middle of DATA.
    sel = 1'b1;
    w0 = wr_b;
    pulse_start();
    send_word(32'd1, 1'b1, 1'b0);
    chk("B in data", 32'(busy_b), 32'd1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    chk("B start ignored", 32'(busy_b), 32'd1);
    q_b.push_back({32'h100, 32'h24080005});
    send_byte(8'h08, 1'b0);
    send_byte(8'h24, 1'b0);
    chk("B done", 32'(done_b), 32'd1);
    step();
    chk("B writes", 32'(wr_b - w0), 32'd1);
    chk("B queue drained", 32'(q_b.size()), 32'd0);
    chk("A untouched", 32'(q_a.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
